multi_ctrled_tick_gen: RTL and testbench
========================================

Name: multi_ctrled_tick_gen

Overview:
Multi-channel successor of the single toggle-controlled tick counter. Each channel has:
- a run/stop toggle;
- a runtime-loadable period;
- periodic or one-shot mode;
- a clear input.

Each channel emits a one-cycle `update` pulse per period. The block drives display-refresh and digit-scan strobes for the multi-counter/display datapath.

Parameters:
- N_CH, 4, number of independent channels (1..8)
- CNT_W, 25, counter and period width in bits
- CNT_MAX, 10000000, reset value of every channel's period register (must fit CNT_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ctrl_flag  in  N_CH  per-channel one-cycle run/stop toggle request
- clr  in  N_CH  per-channel count clear
- mode  in  N_CH  per-channel mode, sampled every cycle: 0 periodic, 1 one-shot
- period_we  in  1  period register write strobe
- period_sel  in  3  channel index for period write; values >= N_CH are ignored
- period_din  in  CNT_W  new period value
- update  out  N_CH  registered one-cycle terminal pulse per channel
- running  out  N_CH  1 when channel is in RUN
- done  out  N_CH  1 when a one-shot channel has finished (state DONE)
- count_o  out  N_CH*CNT_W  current counts; channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset: rst sampled on posedge clk only. On reset every channel goes to:
  - state STOP, count 0, period CNT_MAX;
  - update 0, running 0, done 0.
- Reset mid-operation aborts any count or pending pulse. update is 0 in the cycle after reset is sampled.
- Per-channel states: STOP, RUN, DONE. Encoding is free. running = (state==RUN); done = (state==DONE).
- Terminal condition: term_i = (state==RUN) && (count >= period_i). The >= compare covers a period lowered below the current count.
- RUN, per cycle:
  - if clr: count <= 0, no terminal processing;
  - else if term_i: count <= 0;
  - else: count <= count+1.
- STOP and DONE: count holds unless clr.
- update_i <= term_i && !clr_i, registered. The pulse appears the cycle after count == period and is exactly 1 cycle wide.
- Periodic spacing is period+1 cycles. Period 0 makes update high every cycle while RUN.
- Transitions (priority top-down, evaluated each cycle):
  - One-shot (mode=1), RUN, term_i, !clr → DONE. A simultaneous ctrl_flag is ignored.
  - ctrl_flag, STOP → RUN. Count resumes from the held value (pause semantics).
  - ctrl_flag, RUN → STOP. If term_i occurs in the same cycle, the update still fires and count still wraps to 0.
  - ctrl_flag, DONE → RUN with count <= 0.
  - clr (no ctrl_flag), DONE → STOP.
  - Otherwise state holds.
- clr with ctrl_flag in the same cycle: count <= 0 and the toggle transition applies.
- Period write: when period_we and period_sel < N_CH, period[period_sel] <= period_din at the clock edge. The terminal compare in that same cycle uses the old value; the new value is used from the next cycle. Writes with period_sel >= N_CH have no effect.
- mode changes while RUN take effect at the next terminal.
- Channels are fully independent; there is no shared arbitration.
- count never exceeds max(period, value held when period was lowered). There is no CNT_W overflow path because period <= 2^CNT_W-1.

Test Plan (N_CH=2, CNT_W=8, CNT_MAX=3):
1. Reset, then ctrl_flag[0] pulse at cycle 0.
   - running[0]=1 from cycle 1.
   - update[0] high 1 cycle at cycles 5, 9, 13, …
   - channel 1 remains idle with update[1]=0.
2. Pause/resume: channel 0 running, ctrl_flag[0] when count=2.
   - running=0 and count holds at 3.
   - second ctrl_flag resumes; next update exactly 1 cycle after count reaches 3.
3. One-shot: mode[1]=1, ctrl_flag[1].
   - Single update[1] pulse; done[1]=1; count_o ch1 = 0; no further pulses.
   - ctrl_flag[1] restarts from 0.
   - clr[1] while DONE → STOP with done=0.
4. Period write: period_we, period_sel=0, period_din=0 while ch0 at count 2.
   - Next cycle: count>=0, so count wraps and update every cycle thereafter.
   - Write period_din=9: spacing becomes 10 cycles.
   - period_sel=5: no change to any channel.
5. Simultaneous events:
   - clr[0] in the terminal cycle → no update, count 0.
   - ctrl_flag[0] in the terminal cycle (periodic) → update fires, state STOP, count 0.
   - mode=1, ctrl_flag in the terminal cycle → DONE.
6. rst asserted mid-RUN with count=2:
   - next cycle all outputs 0 and period back to 3;
   - a previously written period is discarded;
   - no update pulse after the reset edge.

Source files
------------

// File: rtl/multi_ctrled_tick_gen.sv
// Multi-channel tick generator: each channel counts to a runtime-loadable period and
// emits a one-cycle update pulse, with run/stop toggle, one-shot mode and clear.
module multi_ctrled_tick_gen #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 25,
  parameter int CNT_MAX = 10000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ctrl_flag,
  input  logic [N_CH-1:0]         clr,
  input  logic [N_CH-1:0]         mode,
  input  logic                    period_we,
  input  logic [2:0]              period_sel,
  input  logic [CNT_W-1:0]        period_din,
  output logic [N_CH-1:0]         update,
  output logic [N_CH-1:0]         running,
  output logic [N_CH-1:0]         done,
  output logic [N_CH*CNT_W-1:0]   count_o
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_e;

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(CNT_MAX);

  state_e           state_q  [N_CH];
  state_e           state_d  [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];
  logic [CNT_W-1:0] count_d  [N_CH];
  logic [CNT_W-1:0] period_q [N_CH];
  logic [CNT_W-1:0] period_d [N_CH];
  logic [N_CH-1:0]  update_q;
  logic [N_CH-1:0]  update_d;
  logic [N_CH-1:0]  term;

  always_comb begin
    term     = '0;
    update_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];

      // >= rather than == so a period lowered below the live count still wraps
      term[i]     = (state_q[i] == ST_RUN) && (count_q[i] >= period_q[i]);
      update_d[i] = term[i] && !clr[i];

      if (clr[i]) begin
        count_d[i] = '0;
      end else if (state_q[i] == ST_RUN) begin
        count_d[i] = term[i] ? '0 : count_q[i] + CNT_W'(1);
      end else if (state_q[i] == ST_DONE && ctrl_flag[i]) begin
        count_d[i] = '0;
      end

      if (state_q[i] == ST_RUN && mode[i] && term[i] && !clr[i]) begin
        state_d[i] = ST_DONE;
      end else if (ctrl_flag[i]) begin
        case (state_q[i])
          ST_STOP: state_d[i] = ST_RUN;
          ST_RUN:  state_d[i] = ST_STOP;
          ST_DONE: state_d[i] = ST_RUN;
          default: state_d[i] = ST_STOP;
        endcase
      end else if (clr[i] && state_q[i] == ST_DONE) begin
        state_d[i] = ST_STOP;
      end

      // Out-of-range selects never match a channel index, so they are dropped
      if (period_we && int'(period_sel) == i) begin
        period_d[i] = period_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= ST_STOP;
        count_q[i]  <= '0;
        period_q[i] <= PERIOD_RST;
      end
    end else begin
      update_q <= update_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  always_comb begin
    count_o = '0;
    running = '0;
    done    = '0;
    for (int i = 0; i < N_CH; i++) begin
      count_o[i*CNT_W +: CNT_W] = count_q[i];
      running[i]                = (state_q[i] == ST_RUN);
      done[i]                   = (state_q[i] == ST_DONE);
    end
  end

  assign update = update_q;

endmodule

// File: tb/tb_multi_ctrled_tick_gen.sv
// Directed bench for multi_ctrled_tick_gen (2 channels, 8-bit counts, reset period 3).
// Each step queues the expected {update, running, done, count_o} for the next edge.
module tb_multi_ctrled_tick_gen;

  localparam int N_CH    = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 3;
  localparam int W       = 3 * N_CH + N_CH * CNT_W;

  logic                  clk;
  logic                  rst;
  logic [N_CH-1:0]       ctrl_flag;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       mode;
  logic                  period_we;
  logic [2:0]            period_sel;
  logic [CNT_W-1:0]      period_din;
  logic [N_CH-1:0]       update;
  logic [N_CH-1:0]       running;
  logic [N_CH-1:0]       done;
  logic [N_CH*CNT_W-1:0] count_o;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  multi_ctrled_tick_gen #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CNT_MAX(CNT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_flag(ctrl_flag), .clr(clr), .mode(mode),
    .period_we(period_we), .period_sel(period_sel), .period_din(period_din),
    .update(update), .running(running), .done(done), .count_o(count_o)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver + scoreboard: queue the expectation, take one edge, compare 1 time unit later
  task automatic step(input string tag, input logic [1:0] upd, input logic [1:0] run,
                      input logic [1:0] dn, input logic [7:0] c0, input logic [7:0] c1);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    exp_q.push_back({upd, run, dn, c1, c0});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {update, running, done, count_o};
    vectors++;
    assert (got_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed upd/run/done/c1/c0=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
             tag, got_v[W-1 -: 2], got_v[W-3 -: 2], got_v[W-5 -: 2], got_v[15:8], got_v[7:0],
             exp_v[W-1 -: 2], exp_v[W-3 -: 2], exp_v[W-5 -: 2], exp_v[15:8], exp_v[7:0]);
    end
    ctrl_flag = '0;
    clr       = '0;
    period_we = 1'b0;
  endtask

  task automatic wr_period(input logic [2:0] sel, input logic [7:0] din);
    period_we  = 1'b1;
    period_sel = sel;
    period_din = din;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; ctrl_flag = '0; clr = '0; mode = '0;
    period_we = 1'b0; period_sel = '0; period_din = '0;

    step("reset0", 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    step("reset1", 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    rst = 1'b0;

    // 1: start ch0, periodic spacing of 4 cycles, ch1 idle
    ctrl_flag = 2'b01;
    step("start0", 2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 3; i++) step("cnt0", 2'b00, 2'b01, 2'b00, 8'(i), 8'd0);
      step("tick0", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);
    end

    // 2: pause at count 2, hold, resume, terminal one cycle later
    step("cnt0", 2'b00, 2'b01, 2'b00, 8'd1, 8'd0);
    step("cnt0", 2'b00, 2'b01, 2'b00, 8'd2, 8'd0);
    ctrl_flag = 2'b01;
    step("pause", 2'b00, 2'b00, 2'b00, 8'd3, 8'd0);
    step("hold", 2'b00, 2'b00, 2'b00, 8'd3, 8'd0);
    step("hold", 2'b00, 2'b00, 2'b00, 8'd3, 8'd0);
    ctrl_flag = 2'b01;
    step("resume", 2'b00, 2'b01, 2'b00, 8'd3, 8'd0);
    step("resume_tick", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);
    ctrl_flag = 2'b01;
    step("stop0", 2'b00, 2'b00, 2'b00, 8'd1, 8'd0);
    clr = 2'b01;
    step("clr_stop", 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);

    // 3: one-shot on ch1, restart, clear out of DONE
    mode = 2'b10;
    for (int k = 0; k < 2; k++) begin
      ctrl_flag = 2'b10;
      step("os_start", 2'b00, 2'b10, 2'b00, 8'd0, 8'd0);
      for (int i = 1; i <= 3; i++) step("os_cnt", 2'b00, 2'b10, 2'b00, 8'd0, 8'(i));
      step("os_fire", 2'b10, 2'b00, 2'b10, 8'd0, 8'd0);
      step("os_quiet", 2'b00, 2'b00, 2'b10, 8'd0, 8'd0);
      step("os_quiet", 2'b00, 2'b00, 2'b10, 8'd0, 8'd0);
    end
    clr = 2'b10;
    step("os_clr", 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    mode = 2'b00;

    // 4: period writes on ch0 (0, then 9, then an out-of-range select)
    ctrl_flag = 2'b01;
    step("start0", 2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
    step("cnt0", 2'b00, 2'b01, 2'b00, 8'd1, 8'd0);
    step("cnt0", 2'b00, 2'b01, 2'b00, 8'd2, 8'd0);
    wr_period(3'd0, 8'd0);
    step("wr0_old", 2'b00, 2'b01, 2'b00, 8'd3, 8'd0);
    for (int i = 0; i < 3; i++) step("p0_tick", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);
    wr_period(3'd0, 8'd9);
    step("wr9_old", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);
    for (int i = 1; i <= 9; i++) step("p9_cnt", 2'b00, 2'b01, 2'b00, 8'(i), 8'd0);
    step("p9_tick", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);
    wr_period(3'd5, 8'd1);
    for (int i = 1; i <= 9; i++) step("sel5_cnt", 2'b00, 2'b01, 2'b00, 8'(i), 8'd0);
    step("sel5_tick", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);

    // 5: simultaneous clr / ctrl_flag with the terminal cycle
    wr_period(3'd0, 8'd3);
    step("wr3", 2'b00, 2'b01, 2'b00, 8'd1, 8'd0);
    step("cnt0", 2'b00, 2'b01, 2'b00, 8'd2, 8'd0);
    step("cnt0", 2'b00, 2'b01, 2'b00, 8'd3, 8'd0);
    clr = 2'b01;
    step("clr_term", 2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
    for (int i = 1; i <= 3; i++) step("cnt0", 2'b00, 2'b01, 2'b00, 8'(i), 8'd0);
    ctrl_flag = 2'b01;
    step("flag_term", 2'b01, 2'b00, 2'b00, 8'd0, 8'd0);
    mode = 2'b01;
    ctrl_flag = 2'b01;
    step("os0_start", 2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
    for (int i = 1; i <= 3; i++) step("os0_cnt", 2'b00, 2'b01, 2'b00, 8'(i), 8'd0);
    ctrl_flag = 2'b01;
    step("os_flag_term", 2'b01, 2'b00, 2'b01, 8'd0, 8'd0);
    clr = 2'b01;
    step("os0_clr", 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    mode = 2'b00;

    // 6: both channels run, ch0 period rewritten, reset mid-run restores period 3
    ctrl_flag = 2'b11;
    step("start_both", 2'b00, 2'b11, 2'b00, 8'd0, 8'd0);
    wr_period(3'd0, 8'd7);
    step("both_cnt", 2'b00, 2'b11, 2'b00, 8'd1, 8'd1);
    step("both_cnt", 2'b00, 2'b11, 2'b00, 8'd2, 8'd2);
    step("both_cnt", 2'b00, 2'b11, 2'b00, 8'd3, 8'd3);
    step("ch1_tick", 2'b10, 2'b11, 2'b00, 8'd4, 8'd0);
    step("both_cnt", 2'b00, 2'b11, 2'b00, 8'd5, 8'd1);
    step("both_cnt", 2'b00, 2'b11, 2'b00, 8'd6, 8'd2);
    rst = 1'b1;
    step("mid_reset", 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    rst = 1'b0;
    ctrl_flag = 2'b01;
    step("post_rst_start", 2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
    for (int i = 1; i <= 3; i++) step("post_rst_cnt", 2'b00, 2'b01, 2'b00, 8'(i), 8'd0);
    step("post_rst_tick", 2'b01, 2'b01, 2'b00, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
